// File: rtl/jk_pkg.sv
// Shared JK drive encodings and helpers for JK-cell based counters.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package jk_pkg;

  // {j,k} pair as seen by a single JK cell.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TOG  = 2'b11
  } jk_e;

  // Counting drive: a bit either toggles or stays, never set/clear.
  function automatic jk_e jk_drive(input logic cur, input logic nxt);
    return (cur ^ nxt) ? JK_TOG : JK_HOLD;
  endfunction

  // Parallel-load drive: force the cell to the requested value.
  function automatic jk_e jk_force(input logic val);
    return val ? JK_SET : JK_CLR;
  endfunction

endpackage

// File: rtl/jk_ff_r.sv
// Single JK flip-flop with asynchronous active-low clear to 0.
// Latency: q updates on the rising clk edge after j/k are sampled.
// Backpressure: none. Ports: clk, rst_n, j, k in; q out.
module jk_ff_r
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_d;
  logic q_q;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD: q_d = q_q;
      JK_CLR:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TOG:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Modulo-MOD up/down counter built from WIDTH JK cells with load, tc, wrap and load-error flags.
// Latency: q, wrap, load_err update one edge after sampling; tc is combinational from q/up_dn.
// Backpressure: none. Ports: clk, rst_n, en, up_dn, load, load_val in; q, tc, wrap, load_err out.
module jk_sync_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("jk_sync_counter: MOD out of range for WIDTH");
  end

  // One extra bit so MOD == 2**WIDTH is representable in comparisons.
  typedef logic [WIDTH:0] cnt_ext_t;
  localparam cnt_ext_t         LIMIT = cnt_ext_t'(MOD);
  localparam cnt_ext_t         LAST  = cnt_ext_t'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO  = '0;

  logic [WIDTH-1:0]      q_cells;
  logic [WIDTH-1:0]      next_cnt;
  logic [WIDTH-1:0][1:0] jk_sel;
  logic [WIDTH-1:0]      j_vec;
  logic [WIDTH-1:0]      k_vec;
  logic                  do_load;
  logic                  do_count;
  logic                  wrap_d, wrap_q;
  logic                  load_err_d, load_err_q;
  cnt_ext_t              q_ext;

  assign q_ext = {1'b0, q_cells};

  always_comb begin
    next_cnt   = q_cells;
    wrap_d     = 1'b0;
    do_load    = load && ({1'b0, load_val} < LIMIT);
    load_err_d = load && !({1'b0, load_val} < LIMIT);
    do_count   = !load && en;

    if (do_count) begin
      if (q_ext >= LIMIT) begin
        // Corrupted state: recover to 0 silently.
        next_cnt = ZERO;
      end else if (up_dn) begin
        if (q_ext == LAST) begin
          next_cnt = ZERO;
          wrap_d   = 1'b1;
        end else begin
          next_cnt = q_cells + ONE;
        end
      end else begin
        if (q_cells == ZERO) begin
          next_cnt = LAST[WIDTH-1:0];
          wrap_d   = 1'b1;
        end else begin
          next_cnt = q_cells - ONE;
        end
      end
    end

    // Rejected loads fall through to hold: the count must not move.
    for (int i = 0; i < WIDTH; i++) begin
      jk_sel[i] = JK_HOLD;
      if (do_load) begin
        jk_sel[i] = jk_force(load_val[i]);
      end else if (do_count) begin
        jk_sel[i] = jk_drive(q_cells[i], next_cnt[i]);
      end
      j_vec[i] = jk_sel[i][1];
      k_vec[i] = jk_sel[i][0];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_ff_r u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_vec[g]),
      .k     (k_vec[g]),
      .q     (q_cells[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign q        = q_cells;
  assign tc       = (up_dn && (q_ext == LAST)) || (!up_dn && (q_cells == ZERO));
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule
